// File: rtl/top_clk_hms.sv
// HH:MM:SS real-time clock with an internal 1 Hz prescaler, cascaded counters,
// per-field range-checked loads, run/pause control and tick/day-wrap/load-error pulses.
module top_clk_hms #(
    parameter int CLK_FREQ_HZ = 50_000_000,
    parameter int MAX_HOURS   = 24
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       run,
    input  logic       load,
    input  logic [1:0] addrs,
    input  logic [5:0] data_in,
    output logic [5:0] seconds_out,
    output logic [5:0] minutes_out,
    output logic [4:0] hours_out,
    output logic       tick_1hz,
    output logic       day_wrap,
    output logic       load_err
);

    localparam int              PW          = $clog2(CLK_FREQ_HZ);
    localparam logic [PW-1:0]   PRE_LAST    = PW'(CLK_FREQ_HZ - 1);
    localparam logic [5:0]      MS_LAST     = 6'd59;
    localparam logic [5:0]      MS_LIMIT    = 6'd60;
    localparam logic [5:0]      HOURS_LIMIT = 6'(MAX_HOURS);
    localparam logic [4:0]      HOUR_LAST   = 5'(MAX_HOURS - 1);

    localparam logic [1:0] ADDR_SEC  = 2'b00;
    localparam logic [1:0] ADDR_MIN  = 2'b01;
    localparam logic [1:0] ADDR_HOUR = 2'b10;
    localparam logic [1:0] ADDR_RSVD = 2'b11;

    logic [PW-1:0] presc_q, presc_d;
    logic [5:0]    sec_q, sec_d;
    logic [5:0]    min_q, min_d;
    logic [4:0]    hour_q, hour_d;
    logic          tick_q, tick_d;
    logic          wrap_q, wrap_d;
    logic          err_q, err_d;

    logic tc;
    logic in_range;
    logic load_ok;
    logic advance;
    logic sec_wrap;
    logic min_wrap;
    logic hour_wrap;

    // Any load in the tc cycle takes priority and swallows that second's advance.
    always_comb begin
        tc        = run && (presc_q == PRE_LAST);
        in_range  = (addrs == ADDR_HOUR) ? (data_in < HOURS_LIMIT) : (data_in < MS_LIMIT);
        load_ok   = load && (addrs != ADDR_RSVD) && in_range;
        advance   = tc && !load;
        sec_wrap  = (sec_q == MS_LAST);
        min_wrap  = (min_q == MS_LAST);
        hour_wrap = (hour_q == HOUR_LAST);

        presc_d = presc_q;
        sec_d   = sec_q;
        min_d   = min_q;
        hour_d  = hour_q;

        if (load_ok && (addrs == ADDR_SEC)) begin
            presc_d = '0;
        end else if (tc) begin
            presc_d = '0;
        end else if (run) begin
            presc_d = presc_q + PW'(1);
        end

        if (advance) begin
            sec_d = sec_wrap ? 6'd0 : sec_q + 6'd1;
            if (sec_wrap) begin
                min_d = min_wrap ? 6'd0 : min_q + 6'd1;
                if (min_wrap) begin
                    hour_d = hour_wrap ? 5'd0 : hour_q + 5'd1;
                end
            end
        end

        if (load_ok) begin
            case (addrs)
                ADDR_SEC:  sec_d  = data_in;
                ADDR_MIN:  min_d  = data_in;
                ADDR_HOUR: hour_d = data_in[4:0];
                default:   ;
            endcase
        end

        tick_d = tc;
        wrap_d = advance && sec_wrap && min_wrap && hour_wrap;
        err_d  = load && !load_ok;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            presc_q <= '0;
            sec_q   <= '0;
            min_q   <= '0;
            hour_q  <= '0;
            tick_q  <= 1'b0;
            wrap_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            presc_q <= presc_d;
            sec_q   <= sec_d;
            min_q   <= min_d;
            hour_q  <= hour_d;
            tick_q  <= tick_d;
            wrap_q  <= wrap_d;
            err_q   <= err_d;
        end
    end

    assign seconds_out = sec_q;
    assign minutes_out = min_q;
    assign hours_out   = hour_q;
    assign tick_1hz    = tick_q;
    assign day_wrap    = wrap_q;
    assign load_err    = err_q;

endmodule
